// File: rtl/clock_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : clock_reset_seq
//  Brief    : NUM_CH-channel clock-domain reset sequencer. Per channel it
//             holds the PLL in reset, waits for lock (with timeout), requires
//             a stable-lock settle period, then releases the domain reset.
//             Runtime lock loss restarts the channel and is counted.
//  Revision : 1.0  initial release
// ============================================================================
module clock_reset_seq #(
    parameter int NUM_CH         = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int SETTLE_CYCLES  = 256,
    parameter int CNT_W          = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sys_reset,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic                  clear_status,
    input  logic [NUM_CH-1:0]     pll_locked_async,
    output logic [NUM_CH-1:0]     pll_reset,
    output logic [NUM_CH-1:0]     domain_reset,
    output logic [NUM_CH-1:0]     ch_ready,
    output logic [NUM_CH-1:0]     ch_timeout,
    output logic [8*NUM_CH-1:0]   lock_loss_count,
    output logic                  all_ready
);

    // Terminal timer values: each state's exit fires when the timer holds N-1.
    localparam logic [CNT_W-1:0] c_pll_rst_last = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timer_one    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    logic [NUM_CH-1:0] w_ch_ready;
    logic              r_all_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             r_sync1;
        logic             r_lock_s;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_timer;
        logic [CNT_W-1:0] w_timer_nxt;
        logic             w_override;
        logic             w_loss_evt;
        logic             w_fault_evt;
        logic             r_pll_reset;
        logic             r_domain_reset;
        logic             r_ch_ready;
        logic             r_ch_timeout;
        logic [7:0]       r_loss_cnt;

        // Restart/disable request wins over every other transition.
        assign w_override = sys_reset | ~ch_enable[i];

        // Two-flop synchroniser bringing raw PLL LOCKED into the clk domain.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1  <= 1'b0;
                r_lock_s <= 1'b0;
            end else begin
                r_sync1  <= pll_locked_async[i];
                r_lock_s <= r_sync1;
            end
        end

        // Channel state and shared per-state timer.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_DISABLED;
                r_timer <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_timer <= w_timer_nxt;
            end
        end

        // Next-state logic; the timer is cleared on every state change.
        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_loss_evt  = 1'b0;
            w_fault_evt = 1'b0;
            if (w_override) begin
                w_state_nxt = ST_DISABLED;
                w_timer_nxt = '0;
            end else begin
                case (r_state)
                    ST_DISABLED: begin
                        w_state_nxt = ST_PLL_RST;
                        w_timer_nxt = '0;
                    end
                    ST_PLL_RST: begin
                        if (r_timer == c_pll_rst_last) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + c_timer_one;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (r_lock_s) begin
                            w_state_nxt = ST_SETTLE;
                            w_timer_nxt = '0;
                        end else if (r_timer == c_timeout_last) begin
                            w_state_nxt = ST_FAULT;
                            w_timer_nxt = '0;
                            w_fault_evt = 1'b1;
                        end else begin
                            w_timer_nxt = r_timer + c_timer_one;
                        end
                    end
                    ST_SETTLE: begin
                        // A single unlocked cycle restarts the whole lock wait.
                        if (!r_lock_s) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_timer_nxt = '0;
                        end else if (r_timer == c_settle_last) begin
                            w_state_nxt = ST_RUN;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + c_timer_one;
                        end
                    end
                    ST_RUN: begin
                        if (!r_lock_s) begin
                            w_state_nxt = ST_PLL_RST;
                            w_timer_nxt = '0;
                            w_loss_evt  = 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        w_state_nxt = ST_FAULT;
                    end
                    default: begin
                        w_state_nxt = ST_DISABLED;
                        w_timer_nxt = '0;
                    end
                endcase
            end
        end

        // Registered outputs decoded from the current state (one cycle behind it).
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pll_reset    <= 1'b1;
                r_domain_reset <= 1'b1;
                r_ch_ready     <= 1'b0;
            end else begin
                r_pll_reset    <= !((r_state == ST_WAIT_LOCK) ||
                                    (r_state == ST_SETTLE)    ||
                                    (r_state == ST_RUN));
                r_domain_reset <= (r_state != ST_RUN);
                r_ch_ready     <= (r_state == ST_RUN);
            end
        end

        // Sticky timeout flag; FAULT entry beats a simultaneous clear.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_ch_timeout <= 1'b0;
            end else if (w_fault_evt) begin
                r_ch_timeout <= 1'b1;
            end else if (clear_status) begin
                r_ch_timeout <= 1'b0;
            end
        end

        // Saturating lock-loss counter; clear with a coincident loss leaves 1.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_loss_cnt <= 8'd0;
            end else if (clear_status) begin
                r_loss_cnt <= w_loss_evt ? 8'd1 : 8'd0;
            end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end

        assign pll_reset[i]              = r_pll_reset;
        assign domain_reset[i]           = r_domain_reset;
        assign ch_ready[i]               = r_ch_ready;
        assign w_ch_ready[i]             = r_ch_ready;
        assign ch_timeout[i]             = r_ch_timeout;
        assign lock_loss_count[8*i +: 8] = r_loss_cnt;
    end

    // Aggregate ready: some channel enabled and every enabled channel in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_all_ready <= 1'b0;
        end else begin
            r_all_ready <= (|ch_enable) && (&(w_ch_ready | ~ch_enable));
        end
    end

    assign all_ready = r_all_ready;

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_reset_seq
//  Brief    : Directed self-checking bench for clock_reset_seq with
//             NUM_CH=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_reset_seq;

    localparam int NUM_CH = 2;

    logic                 clk;
    logic                 reset;
    logic                 sys_reset;
    logic [NUM_CH-1:0]    ch_enable;
    logic                 clear_status;
    logic [NUM_CH-1:0]    pll_locked_async;
    logic [NUM_CH-1:0]    pll_reset;
    logic [NUM_CH-1:0]    domain_reset;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH-1:0]    ch_timeout;
    logic [8*NUM_CH-1:0]  lock_loss_count;
    logic                 all_ready;

    int n_checks = 0;
    int n_errors = 0;

    clock_reset_seq #(
        .NUM_CH         (NUM_CH),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .SETTLE_CYCLES  (8),
        .CNT_W          (17)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sys_reset        (sys_reset),
        .ch_enable        (ch_enable),
        .clear_status     (clear_status),
        .pll_locked_async (pll_locked_async),
        .pll_reset        (pll_reset),
        .domain_reset     (domain_reset),
        .ch_ready         (ch_ready),
        .ch_timeout       (ch_timeout),
        .lock_loss_count  (lock_loss_count),
        .all_ready        (all_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // One-cycle low pulse on ch0 lock; returns just after the edge where the
    // RUN state sees the synchronised loss (optionally with clear_status).
    task automatic ch0_loss_pulse(input logic do_clear);
        pll_locked_async[0] = 1'b0;
        tick();
        pll_locked_async[0] = 1'b1;
        tick();
        clear_status = do_clear;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pll_reset"},    32'(pll_reset),       32'h3);
        check({tag, " domain_reset"}, 32'(domain_reset),    32'h3);
        check({tag, " ch_ready"},     32'(ch_ready),        32'h0);
        check({tag, " ch_timeout"},   32'(ch_timeout),      32'h0);
        check({tag, " loss_count"},   32'(lock_loss_count), 32'h0);
        check({tag, " all_ready"},    32'(all_ready),       32'h0);
    endtask

    initial begin
        reset            = 1'b1;
        sys_reset        = 1'b0;
        ch_enable        = '0;
        clear_status     = 1'b0;
        pll_locked_async = '0;

        // ---------------- Power-up ----------------
        ticks(3);
        check_reset_values("por");
        reset = 1'b0;
        ticks(2);

        ch_enable = 2'b01;
        tick();                                   // ch0 enters PLL_RST
        ticks(4);
        check("pwr pll_reset0 held", 32'(pll_reset[0]), 32'h1);
        tick();
        check("pwr pll_reset0 fall", 32'(pll_reset[0]), 32'h0);
        ticks(10);
        pll_locked_async[0] = 1'b1;
        ticks(11);
        check("pwr dreset0 before", 32'(domain_reset[0]), 32'h1);
        tick();
        check("pwr dreset0 fall",   32'(domain_reset[0]), 32'h0);
        check("pwr ch_ready0",      32'(ch_ready[0]),     32'h1);
        check("pwr all_ready lag",  32'(all_ready),       32'h0);
        tick();
        check("pwr all_ready",      32'(all_ready),       32'h1);
        check("pwr ch1 pll_reset",  32'(pll_reset[1]),    32'h1);
        check("pwr ch1 dreset",     32'(domain_reset[1]), 32'h1);

        // ---------------- Timeout on ch1 ----------------
        ch_enable = 2'b11;
        tick();                                   // ch1 enters PLL_RST
        ticks(5);
        check("to pll_reset1 low", 32'(pll_reset[1]), 32'h0);
        ticks(98);
        check("to not yet",        32'(ch_timeout[1]), 32'h0);
        tick();
        check("to flag set",       32'(ch_timeout[1]), 32'h1);
        tick();
        check("to fault pll_reset", 32'(pll_reset[1]), 32'h1);
        check("to ch0 unaffected",  32'(ch_ready[0]),  32'h1);

        ch_enable = 2'b01;
        tick();
        ch_enable = 2'b11;
        tick();
        ticks(5);
        check("to restart pll_reset1", 32'(pll_reset[1]),  32'h0);
        check("to sticky",             32'(ch_timeout[1]), 32'h1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("to cleared", 32'(ch_timeout), 32'h0);
        ch_enable = 2'b01;
        tick();
        check("to all_ready ch0 only", 32'(all_ready), 32'h1);

        // ---------------- Settle glitch on ch0 ----------------
        ch_enable        = 2'b00;
        pll_locked_async = 2'b00;
        ticks(3);
        ch_enable = 2'b01;
        tick();                                   // PLL_RST
        ticks(5);
        check("glitch pll_reset0 low", 32'(pll_reset[0]), 32'h0);
        pll_locked_async[0] = 1'b1;
        ticks(7);
        pll_locked_async[0] = 1'b0;
        tick();
        pll_locked_async[0] = 1'b1;
        ticks(11);
        check("glitch dreset0 held",   32'(domain_reset[0]), 32'h1);
        tick();
        check("glitch dreset0 release", 32'(domain_reset[0]), 32'h0);
        check("glitch no loss count",  32'(lock_loss_count), 32'h0);

        // ---------------- Runtime lock loss ----------------
        for (int p = 1; p <= 3; p++) begin
            ch0_loss_pulse(1'b0);
            check($sformatf("loss%0d count", p), 32'(lock_loss_count[7:0]), 32'(p));
            tick();
            check($sformatf("loss%0d dreset", p), 32'(domain_reset[0]), 32'h1);
            ticks(13);
            check($sformatf("loss%0d rerun", p), 32'(ch_ready[0]), 32'h1);
        end
        for (int p = 0; p < 297; p++) begin
            ch0_loss_pulse(1'b0);
            ticks(14);
        end
        check("loss saturate 255", 32'(lock_loss_count[7:0]), 32'hFF);
        ch0_loss_pulse(1'b0);
        ticks(14);
        check("loss hold 255", 32'(lock_loss_count[7:0]), 32'hFF);

        // ---------------- Simultaneous events ----------------
        ch0_loss_pulse(1'b1);
        check("clear+loss count", 32'(lock_loss_count[7:0]), 32'h1);
        ticks(14);

        pll_locked_async[1] = 1'b1;
        ch_enable = 2'b11;
        ticks(20);
        check("both ready", 32'(ch_ready),  32'h3);
        check("both all_ready", 32'(all_ready), 32'h1);

        pll_locked_async = 2'b00;
        tick();
        pll_locked_async = 2'b11;
        tick();
        sys_reset = 1'b1;
        tick();                                   // override beats lock loss
        check("sysrst count kept", 32'(lock_loss_count), 32'h0001);
        tick();
        check("sysrst pll_reset", 32'(pll_reset),    32'h3);
        check("sysrst dreset",    32'(domain_reset), 32'h3);
        check("sysrst ch_ready",  32'(ch_ready),     32'h0);
        sys_reset = 1'b0;
        ticks(20);
        check("restart ready", 32'(ch_ready), 32'h3);

        // ---------------- Async reset mid-RUN ----------------
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("arst");
        ticks(2);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
